// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a classic 5-stage in-order core with a
// multi-cycle mul/div unit. It resolves three hazard classes each cycle:
//   * branch/jump mispredict resolved in EX  -> flush IF/ID, bubble ID/EX
//   * load-use dependency (load in EX, consumer in ID) -> one-cycle stall
//   * HI/LO read (or new mul/div) while the mul/div unit is still busy
//     -> stall until the unit finishes
// All pipeline-control outputs are combinational. They settle within the
// high phase of Clk, so the falling-edge pipeline registers see them.
//
// Optional feature:
//   `define HAZARD_PERF_CNT_EN  -> saturating 16-bit perf counters
//                                  StallCycles / FlushCount are built.
//   Without the macro both counters are tied to zero.
//
// Parameters:
//   MD_LATENCY    mul/div occupancy in cycles (2..15); the unit reports busy
//                 for MD_LATENCY-1 cycles after the start cycle.
//
// Ports:
//   Clk             in   clock, state updates on rising edge
//   reset           in   asynchronous active-low reset
//   ID_rs, ID_rt    in   source registers of the instruction in ID
//   ID_UsesRs/Rt    in   ID instruction really reads rs / rt
//   ID_UsesHiLo     in   ID instruction reads HI/LO or is a mul/div
//   EX_MemRead      in   load instruction in EX
//   EX_rt           in   destination register of that load
//   EX_MulDivStart  in   mul/div instruction in EX this cycle
//   EX_Mispredict   in   control-flow instruction in EX was mispredicted
//   PC_Stall        out  hold PC
//   IF_ID_Stall     out  hold IF/ID
//   IF_ID_Flush     out  clear IF/ID
//   Bubble          out  clear all of ID/EX
//   D_Bubble        out  clear control fields of ID/EX, keep PC fields
//   MD_Busy         out  mul/div unit occupied
//   StallCycles     out  edges with PC_Stall=1 (saturating)
//   FlushCount      out  edges with Bubble=1 (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_UsesHiLo,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_rt,
  input  logic        EX_MulDivStart,
  input  logic        EX_Mispredict,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        IF_ID_Flush,
  output logic        Bubble,
  output logic        D_Bubble,
  output logic        MD_Busy,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Counter reload value: the start cycle itself is spent in RUN, so the
  // busy window covers the remaining MD_LATENCY-1 cycles.
  localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] mdcnt_q;
  logic [3:0] mdcnt_d;

  logic       loaduse;
  logic       mdhaz;
  logic       rs_match;
  logic       rt_match;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      mdcnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      mdcnt_q <= mdcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // A mispredict never touches this FSM: the mul/div is older than the
  // mispredicted branch and must be allowed to complete.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mdcnt_d = mdcnt_q;
    unique case (state_q)
      RUN: begin
        if (EX_MulDivStart) begin
          state_d = MD_BUSY;
          mdcnt_d = MD_RELOAD;
        end
      end
      MD_BUSY: begin
        // New starts are ignored here. The <=1 test also recovers from an
        // unreachable zero count instead of wrapping to 15.
        if (mdcnt_q <= 4'd1) begin
          state_d = RUN;
          mdcnt_d = 4'd0;
        end else begin
          mdcnt_d = mdcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        mdcnt_d = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic and hazard resolution
  // -------------------------------------------------------------------------
  // r0 is hardwired zero, so a "load" to r0 never creates a dependency.
  assign rs_match = ID_UsesRs && (ID_rs == EX_rt);
  assign rt_match = ID_UsesRt && (ID_rt == EX_rt);
  assign loaduse  = EX_MemRead && (EX_rt != 5'd0) && (rs_match || rt_match);

  always_comb begin
    MD_Busy     = 1'b0;
    mdhaz       = 1'b0;
    PC_Stall    = 1'b0;
    IF_ID_Stall = 1'b0;
    IF_ID_Flush = 1'b0;
    Bubble      = 1'b0;
    D_Bubble    = 1'b0;
    // Gating with reset keeps every output quiet for the whole time reset is
    // held, even though loaduse is purely combinational.
    if (reset) begin
      MD_Busy = (state_q == MD_BUSY);
      mdhaz   = MD_Busy && ID_UsesHiLo;
      if (EX_Mispredict) begin
        // Wrong-path instructions in IF and ID are discarded; stalling them
        // would be pointless, so the flush wins over any stall request.
        Bubble      = 1'b1;
        IF_ID_Flush = 1'b1;
      end else if (loaduse || mdhaz) begin
        // Hold the front end and inject a nop into EX. PC fields of ID/EX
        // are kept so exception/PC bookkeeping stays intact.
        PC_Stall    = 1'b1;
        IF_ID_Stall = 1'b1;
        D_Bubble    = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PC_Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (Bubble && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = 16'd0;
  assign FlushCount  = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, mul/div occupancy in cycles (legal 2..15).
REQ-002 SHALL have ports: Clk  input  1  single clock, state updates on rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ID_rs, ID_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports: ID_UsesRs, ID_UsesRt, ID_UsesHiLo  input  1 each  ID instruction reads rs / rt / HI-LO or is mul/div.
REQ-006 SHALL have ports: EX_MemRead  input  1, EX_rt  input  5  load in EX and its destination.
REQ-007 SHALL have ports: EX_MulDivStart  input  1  mul/div instruction in EX this cycle.
REQ-008 SHALL have ports: EX_Mispredict  input  1  branch/jump resolved in EX disagrees with EX_Predict.
REQ-009 SHALL have ports: PC_Stall, IF_ID_Stall, IF_ID_Flush  output  1 each  front-end hold/clear.
REQ-010 SHALL have ports: Bubble  output  1  full clear of ID/EX; D_Bubble  output  1  control clear of ID/EX, PC fields kept.
REQ-011 SHALL have ports: MD_Busy  output  1; StallCycles, FlushCount  output  16 each  perf counters.

Function
REQ-012 SHALL implement FSM states RUN and MD_BUSY plus 4-bit down-counter mdcnt.
REQ-013 SHALL, in RUN with EX_MulDivStart=1, load mdcnt=MD_LATENCY-1 and enter MD_BUSY on next edge.
REQ-014 SHALL, in MD_BUSY, decrement mdcnt each edge; at mdcnt=1 go to RUN (mdcnt->0); MD_Busy=1 exactly while in MD_BUSY.
REQ-015 SHALL ignore EX_MulDivStart while in MD_BUSY (no reload).
REQ-016 SHALL define loaduse = EX_MemRead & (EX_rt!=0) & ((ID_UsesRs & ID_rs==EX_rt) | (ID_UsesRt & ID_rt==EX_rt)), combinational.
REQ-017 SHALL define mdhaz = MD_Busy & ID_UsesHiLo, combinational.
REQ-018 SHALL, when EX_Mispredict=1, assert Bubble=1, IF_ID_Flush=1, PC_Stall=0, IF_ID_Stall=0, D_Bubble=0, same cycle (zero latency).
REQ-019 SHALL, when EX_Mispredict=0 and (loaduse | mdhaz), assert PC_Stall=IF_ID_Stall=D_Bubble=1, Bubble=IF_ID_Flush=0.
REQ-020 SHALL otherwise drive all five pipeline-control outputs 0.
REQ-021 SHALL let mispredict not disturb FSM/mdcnt (mul/div is older, completes).
REQ-022 SHALL produce load-use stall of exactly one cycle (ID/EX holds nop next cycle, so loaduse deasserts).
REQ-023 SHALL hold mdhaz stall until the cycle MD_Busy falls; ID instruction proceeds the cycle after.
REQ-024 SHALL make all outputs valid before the falling Clk edge (pipeline registers capture on falling edge).

Reset
REQ-025 SHALL, while reset=0, force state RUN, mdcnt=0, MD_Busy=0, counters 0, all pipeline-control outputs 0.
REQ-026 SHALL, on reset assertion mid-MD_BUSY, abandon the count immediately; first edge after release is RUN.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, increment StallCycles on each edge where PC_Stall=1 and FlushCount on each edge where Bubble=1, each saturating at 0xFFFF.
REQ-028 SHALL, without HAZARD_PERF_CNT_EN, omit counter logic and tie StallCycles and FlushCount to 0.

Verification
REQ-029 Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5, ID_UsesRs=1 -> one cycle PC_Stall=IF_ID_Stall=D_Bubble=1; same with EX_rt=0 -> no stall.
REQ-030 Mul/div: MD_LATENCY=4, EX_MulDivStart pulse, ID_UsesHiLo=1 held -> MD_Busy=1 for 3 cycles, stall outputs 1 for those 3 cycles, then 0.
REQ-031 Priority: EX_Mispredict=1 with loaduse=1 -> Bubble=1, IF_ID_Flush=1, PC_Stall=0, D_Bubble=0.
REQ-032 Reset mid-op: reset=0 at mdcnt=2 -> MD_Busy=0 immediately, counters 0; after release no stall.
REQ-033 Counters (macro on): 70000 forced stall cycles -> StallCycles=0xFFFF; macro off -> both counters 0.
